// File: rtl/lfsr_pkg.sv
// Shared types and constants for the LFSR burst arbiter: state encoding, LFSR geometry, seed fix-up.
// Pure declarations; no latency or backpressure of its own.
package lfsr_pkg;

    localparam int LFSR_W = 4;
    localparam int CNT_W  = 4;

    // Feedback taps L[0]^L[1]^L[2], shifted into the MSB.
    localparam logic [LFSR_W-1:0] LFSR_TAPS          = 4'b0111;
    localparam logic [LFSR_W-1:0] LFSR_ZERO_SEED_FIX = 4'b0001;
    localparam logic [LFSR_W-1:0] LFSR_RESET_VAL     = 4'b0001;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_WARM   = 3'd2,
        ST_STREAM = 3'd3,
        ST_FIN    = 3'd4
    } arb_state_t;

    function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] cur);
        return {^(cur & LFSR_TAPS), cur[LFSR_W-1:1]};
    endfunction

    // An all-zero register would never leave zero, so it is never loaded.
    function automatic logic [LFSR_W-1:0] seed_fix(input logic [LFSR_W-1:0] seed);
        return (seed == '0) ? LFSR_ZERO_SEED_FIX : seed;
    endfunction

endpackage

// File: rtl/lfsr_arb_ctrl_if.sv
// Request/seed/grant and serial-bit handshake bundle between requesters, consumer and arbiter.
// Wiring only; READY is the consumer's backpressure on OUT/VALID.
interface lfsr_arb_ctrl_if #(
    parameter int NREQ = 4
) ();

    logic [NREQ-1:0]                  REQ;
    logic [lfsr_pkg::LFSR_W*NREQ-1:0] SEED;
    logic                             READY;
    logic [NREQ-1:0]                  GNT;
    logic                             OUT;
    logic                             VALID;
    logic                             DONE;
    logic                             BUSY;

    modport master (
        output REQ, SEED, READY,
        input  GNT, OUT, VALID, DONE, BUSY
    );

    modport slave (
        input  REQ, SEED, READY,
        output GNT, OUT, VALID, DONE, BUSY
    );

endinterface

// File: rtl/lfsr_core.sv
// 4-bit Fibonacci LFSR with synchronous seed load (zero seed fixed up) and shift enable.
// Load/shift take effect on the next edge; holds when neither is asserted.
module lfsr_core
    import lfsr_pkg::*;
(
    input  logic              CLK,
    input  logic              RST,
    input  logic              load,
    input  logic              shift_en,
    input  logic [LFSR_W-1:0] seed,
    output logic [LFSR_W-1:0] state
);

    logic [LFSR_W-1:0] lfsr_q;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            lfsr_q <= LFSR_RESET_VAL;
        end else if (load) begin
            lfsr_q <= seed_fix(seed);
        end else if (shift_en) begin
            lfsr_q <= lfsr_next(lfsr_q);
        end
    end

    assign state = lfsr_q;

endmodule

// File: rtl/lfsr_arb_ctrl.sv
// Round-robin arbiter granting one requester a seeded, warmed-up LFSR burst of BURST serial bits.
// GNT one cycle after REQ, first VALID at 2+WARMUP; READY low stalls OUT/LFSR/counter.
module lfsr_arb_ctrl
    import lfsr_pkg::*;
#(
    parameter int NREQ   = 4,
    parameter int WARMUP = 8,
    parameter int BURST  = 4
) (
    input  logic           CLK,
    input  logic           RST,
    lfsr_arb_ctrl_if.slave bus
);

    localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [CNT_W-1:0] WARM_LAST  = CNT_W'(WARMUP - 1);
    localparam logic [CNT_W-1:0] BURST_LAST = CNT_W'(BURST - 1);

    arb_state_t        state_q;
    arb_state_t        state_d;
    logic [IDX_W-1:0]  rr_ptr_q;
    logic [IDX_W-1:0]  win_q;
    logic [IDX_W-1:0]  pick;
    logic              pick_vld;
    logic [NREQ-1:0]   gnt_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [LFSR_W-1:0] lfsr_state;
    logic [LFSR_W-1:0] seed_arr [NREQ];
    logic              req_held;
    logic              accept;
    logic              valid;
    logic              done;
    logic              busy;
    logic              lfsr_load;
    logic              lfsr_shift;

    for (genvar g = 0; g < NREQ; g++) begin : g_seed
        assign seed_arr[g] = bus.SEED[g*LFSR_W +: LFSR_W];
    end

    // First active request at or after the rotating pointer wins.
    always_comb begin
        pick     = rr_ptr_q;
        pick_vld = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            if (!pick_vld && bus.REQ[IDX_W'((int'(rr_ptr_q) + k) % NREQ)]) begin
                pick     = IDX_W'((int'(rr_ptr_q) + k) % NREQ);
                pick_vld = 1'b1;
            end
        end
    end

    // Only the granted requester's level matters once a burst has started.
    assign req_held = |(bus.REQ & gnt_q);
    assign accept   = valid && bus.READY;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        valid   = 1'b0;
        done    = 1'b0;
        busy    = 1'b1;
        unique case (state_q)
            ST_IDLE: begin
                busy = 1'b0;
                if (pick_vld) begin
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                state_d = req_held ? ST_WARM : ST_IDLE;
            end
            ST_WARM: begin
                if (!req_held) begin
                    state_d = ST_IDLE;
                end else if (cnt_q == WARM_LAST) begin
                    state_d = ST_STREAM;
                end
            end
            ST_STREAM: begin
                valid = 1'b1;
                if (!req_held) begin
                    state_d = ST_IDLE;
                end else if (bus.READY && (cnt_q == BURST_LAST)) begin
                    state_d = ST_FIN;
                end
            end
            ST_FIN: begin
                done    = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Pointer moves at grant time, so an aborted burst still hands priority on.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            gnt_q    <= '0;
            win_q    <= '0;
            rr_ptr_q <= '0;
        end else if ((state_q == ST_IDLE) && pick_vld) begin
            gnt_q    <= NREQ'(1) << pick;
            win_q    <= pick;
            rr_ptr_q <= IDX_W'((int'(pick) + 1) % NREQ);
        end else if ((state_q != ST_IDLE) && (state_d == ST_IDLE)) begin
            gnt_q    <= '0;
        end
    end

    // One counter serves warm-up and bit counting; any state change restarts it.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            cnt_q <= '0;
        end else if (state_d != state_q) begin
            cnt_q <= '0;
        end else if ((state_q == ST_WARM) || accept) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign lfsr_load  = (state_q == ST_LOAD);
    assign lfsr_shift = (state_q == ST_WARM) || accept;

    lfsr_core u_lfsr_core (
        .CLK      (CLK),
        .RST      (RST),
        .load     (lfsr_load),
        .shift_en (lfsr_shift),
        .seed     (seed_arr[win_q]),
        .state    (lfsr_state)
    );

    assign bus.GNT   = gnt_q;
    assign bus.VALID = valid;
    assign bus.OUT   = valid & lfsr_state[0];
    assign bus.DONE  = done;
    assign bus.BUSY  = busy;

    a_gnt_onehot: assert property (@(posedge CLK) disable iff (!RST) $onehot0(gnt_q));
    a_valid_gnt:  assert property (@(posedge CLK) disable iff (!RST) valid |-> (gnt_q != '0));
    a_no_lockup:  assert property (@(posedge CLK) disable iff (!RST) lfsr_state != '0);

endmodule

// File: doc/lfsr_arb_ctrl.md
LFSR_ARB_CTRL -- requirements
Module: lfsr_arb_ctrl

Interface
REQ-001 Parameter NREQ, default 4, SHALL set the number of requesters; fixed at 4 in this release.
REQ-002 Parameter WARMUP, default 8, SHALL set the number of discarded shifts after seed load (1..15).
REQ-003 Parameter BURST, default 4, SHALL set the number of bits delivered per grant (1..15).
REQ-004 CLK  in  1  SHALL be the single clock; all state updates on posedge.
REQ-005 RST  in  1  SHALL be the asynchronous, active-low reset.
REQ-006 REQ  in  4  SHALL carry per-requester burst requests; level, held until DONE.
REQ-007 SEED  in  16  SHALL carry per-requester 4-bit seeds; requester i uses SEED[4i+3:4i].
REQ-008 READY  in  1  SHALL be the consumer ready for OUT.
REQ-009 GNT  out  4  SHALL be the one-hot grant, all zeros when idle.
REQ-010 OUT  out  1  SHALL be the random serial bit.
REQ-011 VALID  out  1  SHALL qualify OUT.
REQ-012 DONE  out  1  SHALL be a one-cycle pulse at burst completion.
REQ-013 BUSY  out  1  SHALL be high in every state except IDLE.

Function
REQ-014 FSM states SHALL be IDLE, LOAD, WARM, STREAM, FIN.
REQ-015 IDLE: with any REQ bit high, the arbiter SHALL pick a winner round-robin, starting at the index after the last granted requester (after reset: index 0), then go to LOAD.
REQ-016 LOAD: GNT SHALL be set to the winner, the LFSR loaded with the winner's seed, the counter cleared; next state WARM.
REQ-017 A zero seed SHALL be replaced by 4'b0001 at load to avoid lock-up.
REQ-018 LFSR update SHALL be L <= {L[0]^L[1]^L[2], L[3:1]}; next-bit output is L[0].
REQ-019 WARM: the LFSR SHALL shift once per cycle for exactly WARMUP cycles with VALID=0; then STREAM.
REQ-020 STREAM: VALID=1 and OUT=L[0]; on VALID&&READY the LFSR SHALL shift and the bit counter increment.
REQ-021 READY low SHALL stall: OUT, VALID, LFSR and counter hold.
REQ-022 After the BURST-th accepted bit, the next state SHALL be FIN: DONE=1 for one cycle, VALID=0, GNT cleared on exit; then IDLE.
REQ-023 Latency: REQ seen in IDLE at cycle 0 -> GNT at cycle 1 -> first VALID at cycle 2+WARMUP.
REQ-024 If the granted REQ bit drops in LOAD, WARM or STREAM, the FSM SHALL abort to IDLE next cycle with GNT=0, VALID=0, no DONE pulse; round-robin pointer still advances.
REQ-025 REQ changes of non-granted requesters SHALL have no effect until the next IDLE arbitration.
REQ-026 Counter widths SHALL be 4 bits; no wrap-around occurs within the allowed parameter ranges.

Reset
REQ-027 On RST low: state IDLE, GNT=0, OUT=0, VALID=0, DONE=0, BUSY=0, LFSR=4'b0001, counters 0, RR pointer at index 0, regardless of state at assertion.
REQ-028 Reset deassertion SHALL allow first arbitration on the first following posedge.

Structure
REQ-029 A shared package lfsr_pkg SHALL hold the FSM state enum, the LFSR width (4), the tap mask, and the zero-seed replacement constant.
REQ-030 The shift register SHALL be a sub-module lfsr_core (load, shift enable, seed in, state out); the arbiter and FSM stay in lfsr_arb_ctrl.

Verification
REQ-031 REQ=4'b0001, SEED[3:0]=4'b1001, READY=1 -> GNT=0001 at cycle 1; VALID at cycle 10; OUT=0,0,1,1; DONE pulse at cycle 14.
REQ-032 REQ=4'b1111 held for 4 bursts -> grant order 0,1,2,3, then 0 again.
REQ-033 SEED[7:4]=0, REQ=4'b0010 -> LFSR loads 4'b0001; output not stuck at 0.
REQ-034 READY toggled 1,0,0,1 during STREAM -> OUT held and no shift during the low cycles; exactly 4 bits accepted.
REQ-035 Granted REQ dropped during WARM -> IDLE next cycle, GNT=0, no DONE.
REQ-036 RST asserted mid-STREAM -> all outputs 0 immediately (asynchronous); after release, REQ=4'b0100 is granted normally.
